// File: rtl/axi_read_arbiter_pkg.sv
// Shared definitions for the two-master AXI read arbiter.
//   - default bus widths used as parameter defaults
//   - master tag constants prepended to ARID on the slave side
//   - arbiter FSM state type
package axi_read_arbiter_pkg;

    localparam int DEF_ID_W   = 4;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_LEN_W  = 4;
    localparam int DEF_SIZE_W = 3;

    localparam int TAG_W = 4;
    localparam logic [TAG_W-1:0] TAG_M0 = 4'b0001;
    localparam logic [TAG_W-1:0] TAG_M1 = 4'b0010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

endpackage

// File: rtl/axi_read_arbiter_if.sv
// AXI read channel bundle (AR + R) for one link.
//   master modport : drives AR request and RREADY, receives ARREADY and R beat
//   slave modport  : receives AR request and RREADY, drives ARREADY and R beat
// ID_W is set per instance: master links carry the raw ID, the slave link
// carries the ID widened by the master tag.
interface axi_read_arbiter_if #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4,
    parameter int SIZE_W = 3
);
    logic [ID_W-1:0]   ARID;
    logic [ADDR_W-1:0] ARADDR;
    logic [LEN_W-1:0]  ARLEN;
    logic [SIZE_W-1:0] ARSIZE;
    logic [1:0]        ARBURST;
    logic              ARVALID;
    logic              ARREADY;

    logic [ID_W-1:0]   RID;
    logic [DATA_W-1:0] RDATA;
    logic [1:0]        RRESP;
    logic              RLAST;
    logic              RVALID;
    logic              RREADY;

    modport master (
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
        input  ARREADY, RID, RDATA, RRESP, RLAST, RVALID
    );

    modport slave (
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
        output ARREADY, RID, RDATA, RRESP, RLAST, RVALID
    );
endinterface

// File: rtl/axi_read_arbiter_rr_arb2.sv
// Two-way round-robin selector (combinational).
//   req[1:0] : request from M1/M0
//   last     : master granted last (0 = M0, 1 = M1)
//   gnt[1:0] : one-hot grant; a lone requester always wins, on a tie the
//              master that was not granted last wins
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);
    always_comb begin
        gnt = '0;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = '0;
        endcase
    end
endmodule

// File: rtl/axi_read_arbiter.sv
// Two-master to one-slave AXI read arbiter, one transaction at a time.
//   ACLK, ARESETn : clock, synchronous active-low reset
//   m0, m1        : master links (arbiter acts as their slave)
//   s             : slave link (ARID widened by a 4-bit master tag)
//   PROT_ERR      : sticky flag, RLAST disagreed with the expected beat count
// Read data is routed by the registered grant, never by the returned RID.
module axi_read_arbiter
    import axi_read_arbiter_pkg::*;
#(
    parameter int ID_W   = DEF_ID_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = DEF_LEN_W,
    parameter int SIZE_W = DEF_SIZE_W
) (
    input  logic                 ACLK,
    input  logic                 ARESETn,
    axi_read_arbiter_if.slave    m0,
    axi_read_arbiter_if.slave    m1,
    axi_read_arbiter_if.master   s,
    output logic                 PROT_ERR
);
    state_t                  r_state;
    logic                    r_last;
    logic                    r_gnt;
    logic [ID_W+TAG_W-1:0]   r_arid;
    logic [ADDR_W-1:0]       r_araddr;
    logic [LEN_W-1:0]        r_arlen;
    logic [SIZE_W-1:0]       r_arsize;
    logic [1:0]              r_arburst;
    logic                    r_arvalid;
    logic [LEN_W-1:0]        r_cnt;
    logic                    r_prot_err;

    logic [1:0]              w_req;
    logic [1:0]              w_gnt;
    logic                    w_idle;
    logic                    w_data;
    logic                    w_rready_g;
    logic                    w_rbeat;
    logic [DATA_W-1:0]       w_rdata;
    logic                    w_unused_rid_tag;

    assign w_req = {m1.ARVALID, m0.ARVALID};

    rr_arb2 u_rr_arb2 (
        .req  (w_req),
        .last (r_last),
        .gnt  (w_gnt)
    );

    assign w_idle     = (r_state == ST_IDLE);
    assign w_data     = (r_state == ST_DATA);
    assign w_rready_g = r_gnt ? m1.RREADY : m0.RREADY;
    assign w_rbeat    = w_data & s.RVALID & w_rready_g;
    assign w_rdata    = s.RDATA;

    // Upper RID bits carry the tag; routing ignores them by design.
    assign w_unused_rid_tag = &{1'b0, s.RID[ID_W+TAG_W-1:ID_W]};

    assign m0.ARREADY = w_idle & w_gnt[0];
    assign m1.ARREADY = w_idle & w_gnt[1];

    assign s.ARID    = r_arid;
    assign s.ARADDR  = r_araddr;
    assign s.ARLEN   = r_arlen;
    assign s.ARSIZE  = r_arsize;
    assign s.ARBURST = r_arburst;
    assign s.ARVALID = r_arvalid;
    assign s.RREADY  = w_data & w_rready_g;

    assign m0.RVALID = w_data & ~r_gnt & s.RVALID;
    assign m1.RVALID = w_data &  r_gnt & s.RVALID;
    assign m0.RID    = s.RID[ID_W-1:0];
    assign m1.RID    = s.RID[ID_W-1:0];
    assign m0.RDATA  = w_rdata;
    assign m1.RDATA  = w_rdata;
    assign m0.RRESP  = s.RRESP;
    assign m1.RRESP  = s.RRESP;
    assign m0.RLAST  = s.RLAST;
    assign m1.RLAST  = s.RLAST;

    assign PROT_ERR = r_prot_err;

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            r_state    <= ST_IDLE;
            r_last     <= 1'b1;
            r_gnt      <= 1'b0;
            r_arid     <= '0;
            r_araddr   <= '0;
            r_arlen    <= '0;
            r_arsize   <= '0;
            r_arburst  <= '0;
            r_arvalid  <= 1'b0;
            r_cnt      <= '0;
            r_prot_err <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (|w_gnt) begin
                        r_gnt     <= w_gnt[1];
                        r_arvalid <= 1'b1;
                        r_state   <= ST_ADDR;
                        if (w_gnt[1]) begin
                            r_arid    <= {TAG_M1, m1.ARID};
                            r_araddr  <= m1.ARADDR;
                            r_arlen   <= m1.ARLEN;
                            r_arsize  <= m1.ARSIZE;
                            r_arburst <= m1.ARBURST;
                        end else begin
                            r_arid    <= {TAG_M0, m0.ARID};
                            r_araddr  <= m0.ARADDR;
                            r_arlen   <= m0.ARLEN;
                            r_arsize  <= m0.ARSIZE;
                            r_arburst <= m0.ARBURST;
                        end
                    end
                end
                ST_ADDR: begin
                    if (s.ARREADY) begin
                        r_arvalid <= 1'b0;
                        r_cnt     <= '0;
                        r_state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_rbeat) begin
                        r_cnt <= r_cnt + 1'b1;
                        // Beat r_cnt is the last one exactly when r_cnt == ARLEN.
                        if (s.RLAST != (r_cnt == r_arlen))
                            r_prot_err <= 1'b1;
                        if (s.RLAST) begin
                            r_last  <= r_gnt;
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed self-checking bench for axi_read_arbiter.
module tb_axi_read_arbiter;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    logic prot_err;

    always #5 clk = ~clk;

    axi_read_arbiter_if #(.ID_W(4), .ADDR_W(32), .DATA_W(32), .LEN_W(4), .SIZE_W(3)) m0_if ();
    axi_read_arbiter_if #(.ID_W(4), .ADDR_W(32), .DATA_W(32), .LEN_W(4), .SIZE_W(3)) m1_if ();
    axi_read_arbiter_if #(.ID_W(8), .ADDR_W(32), .DATA_W(32), .LEN_W(4), .SIZE_W(3)) s_if ();

    axi_read_arbiter #(
        .ID_W   (4),
        .ADDR_W (32),
        .DATA_W (32),
        .LEN_W  (4),
        .SIZE_W (3)
    ) dut (
        .ACLK     (clk),
        .ARESETn  (rstn),
        .m0       (m0_if),
        .m1       (m1_if),
        .s        (s_if),
        .PROT_ERR (prot_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic idle_inputs;
        m0_if.ARVALID = 1'b0; m0_if.ARID = '0; m0_if.ARADDR = '0; m0_if.ARLEN = '0;
        m0_if.ARSIZE = '0; m0_if.ARBURST = '0; m0_if.RREADY = 1'b1;
        m1_if.ARVALID = 1'b0; m1_if.ARID = '0; m1_if.ARADDR = '0; m1_if.ARLEN = '0;
        m1_if.ARSIZE = '0; m1_if.ARBURST = '0; m1_if.RREADY = 1'b1;
        s_if.ARREADY = 1'b0; s_if.RVALID = 1'b0; s_if.RID = '0; s_if.RDATA = '0;
        s_if.RRESP = '0; s_if.RLAST = 1'b0;
    endtask

    task automatic req(input int m, input logic [3:0] id, input logic [31:0] addr,
                       input logic [3:0] len);
        if (m == 0) begin
            m0_if.ARVALID = 1'b1; m0_if.ARID = id; m0_if.ARADDR = addr;
            m0_if.ARLEN = len; m0_if.ARSIZE = 3'd2; m0_if.ARBURST = 2'b01;
        end else begin
            m1_if.ARVALID = 1'b1; m1_if.ARID = id; m1_if.ARADDR = addr;
            m1_if.ARLEN = len; m1_if.ARSIZE = 3'd2; m1_if.ARBURST = 2'b01;
        end
    endtask

    task automatic drop_req;
        m0_if.ARVALID = 1'b0;
        m1_if.ARVALID = 1'b0;
    endtask

    task automatic addr_hs;
        s_if.ARREADY = 1'b1;
        tick();
        s_if.ARREADY = 1'b0;
    endtask

    // Drives n beats (RLAST on beat last_idx) and counts beats handed to each master.
    task automatic run_beats(input int n, input int last_idx, output int seen0, output int seen1);
        seen0 = 0;
        seen1 = 0;
        for (int i = 0; i < n; i++) begin
            s_if.RVALID = 1'b1;
            s_if.RDATA  = 32'hC0DE_0000 + 32'(i);
            s_if.RLAST  = (i == last_idx);
            settle();
            if (m0_if.RVALID && s_if.RREADY) seen0++;
            if (m1_if.RVALID && s_if.RREADY) seen1++;
            tick();
        end
        s_if.RVALID = 1'b0;
        s_if.RLAST  = 1'b0;
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        idle_inputs();
        tick();
        tick();
        n_checks++; if (s_if.ARVALID !== 1'b0) begin n_fail++; $display("FAIL reset_arvalid_s: got %b expected 0", s_if.ARVALID); end
        n_checks++; if (s_if.RREADY !== 1'b0) begin n_fail++; $display("FAIL reset_rready_s: got %b expected 0", s_if.RREADY); end
        n_checks++; if ({m1_if.RVALID, m0_if.RVALID} !== 2'b00) begin n_fail++; $display("FAIL reset_rvalid_m: got %b expected 00", {m1_if.RVALID, m0_if.RVALID}); end
        n_checks++; if (prot_err !== 1'b0) begin n_fail++; $display("FAIL reset_prot_err: got %b expected 0", prot_err); end
        n_checks++; if ({s_if.ARID, s_if.ARADDR} !== 40'h0) begin n_fail++; $display("FAIL reset_ar_fields: got %h expected 0", {s_if.ARID, s_if.ARADDR}); end
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_single;
        req(0, 4'h1, 32'h0000_1000, 4'd3);
        settle();
        n_checks++; if ({m1_if.ARREADY, m0_if.ARREADY} !== 2'b01) begin n_fail++; $display("FAIL single_arready: got %b expected 01", {m1_if.ARREADY, m0_if.ARREADY}); end
        tick();
        drop_req();
        settle();
        n_checks++; if (s_if.ARVALID !== 1'b1) begin n_fail++; $display("FAIL single_arvalid_s: got %b expected 1", s_if.ARVALID); end
        n_checks++; if (s_if.ARID !== 8'h11) begin n_fail++; $display("FAIL single_arid_s: got %h expected 11", s_if.ARID); end
        n_checks++; if ({s_if.ARADDR, s_if.ARLEN} !== {32'h0000_1000, 4'd3}) begin n_fail++; $display("FAIL single_addr_len: got %h expected 000010003", {s_if.ARADDR, s_if.ARLEN}); end
        addr_hs();
        n_checks++; if (s_if.ARVALID !== 1'b0) begin n_fail++; $display("FAIL single_arvalid_drop: got %b expected 0", s_if.ARVALID); end
        for (int i = 0; i < 4; i++) begin
            s_if.RVALID = 1'b1;
            s_if.RID    = 8'h11;
            s_if.RDATA  = 32'hA000_0000 + 32'(i);
            s_if.RLAST  = (i == 3);
            settle();
            n_checks++; if ({m1_if.RVALID, m0_if.RVALID, s_if.RREADY} !== 3'b011) begin n_fail++; $display("FAIL single_beat%0d_valid: got m1v/m0v/rrdy=%b expected 011", i, {m1_if.RVALID, m0_if.RVALID, s_if.RREADY}); end
            n_checks++; if ({m0_if.RID, m0_if.RDATA} !== {4'h1, 32'hA000_0000 + 32'(i)}) begin n_fail++; $display("FAIL single_beat%0d_data: got %h expected %h", i, {m0_if.RID, m0_if.RDATA}, {4'h1, 32'hA000_0000 + 32'(i)}); end
            tick();
        end
        s_if.RLAST = 1'b0;
        settle();
        n_checks++; if (prot_err !== 1'b0) begin n_fail++; $display("FAIL single_prot_err: got %b expected 0", prot_err); end
        // RVALID_S is still high here but the FSM is idle: it must be ignored.
        n_checks++; if ({s_if.RREADY, m0_if.RVALID, m1_if.RVALID} !== 3'b000) begin n_fail++; $display("FAIL idle_stray_rvalid: got %b expected 000", {s_if.RREADY, m0_if.RVALID, m1_if.RVALID}); end
        s_if.RVALID = 1'b0;
        tick();
    endtask

    task automatic test_round_robin;
        int s0, s1;
        logic odd;
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            odd = (k % 2 == 1);
            req(0, 4'(k), 32'h0000_0100 * 32'(k), 4'd0);
            req(1, 4'(k + 8), 32'h0001_0000 + 32'(k), 4'd0);
            settle();
            n_checks++; if ({m1_if.ARREADY, m0_if.ARREADY} !== (odd ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL rr%0d_arready: got %b expected %b", k, {m1_if.ARREADY, m0_if.ARREADY}, odd ? 2'b10 : 2'b01); end
            tick();
            drop_req();
            settle();
            n_checks++; if (s_if.ARID !== (odd ? {4'b0010, 4'(k + 8)} : {4'b0001, 4'(k)})) begin n_fail++; $display("FAIL rr%0d_arid_s: got %h expected %h", k, s_if.ARID, odd ? {4'b0010, 4'(k + 8)} : {4'b0001, 4'(k)}); end
            addr_hs();
            run_beats(1, 0, s0, s1);
            n_checks++; if ({s1, s0} !== (odd ? {32'd1, 32'd0} : {32'd0, 32'd1})) begin n_fail++; $display("FAIL rr%0d_route: got m0=%0d m1=%0d expected m0=%0d m1=%0d", k, s0, s1, odd ? 0 : 1, odd ? 1 : 0); end
        end
    endtask

    task automatic test_addr_stall;
        int s0, s1;
        req(1, 4'h5, 32'hDEAD_BEE0, 4'd1);
        tick();
        drop_req();
        req(0, 4'hF, 32'h0000_7000, 4'd0);
        for (int c = 0; c < 5; c++) begin
            settle();
            n_checks++; if ({s_if.ARVALID, s_if.ARID, s_if.ARADDR, s_if.ARLEN, s_if.ARSIZE, s_if.ARBURST} !== {1'b1, 8'h25, 32'hDEAD_BEE0, 4'd1, 3'd2, 2'b01}) begin n_fail++; $display("FAIL stall%0d_ar_fields: got %h expected %h", c, {s_if.ARVALID, s_if.ARID, s_if.ARADDR, s_if.ARLEN, s_if.ARSIZE, s_if.ARBURST}, {1'b1, 8'h25, 32'hDEAD_BEE0, 4'd1, 3'd2, 2'b01}); end
            n_checks++; if ({m1_if.ARREADY, m0_if.ARREADY} !== 2'b00) begin n_fail++; $display("FAIL stall%0d_arready_m: got %b expected 00", c, {m1_if.ARREADY, m0_if.ARREADY}); end
            tick();
        end
        drop_req();
        addr_hs();
        run_beats(2, 1, s0, s1);
        n_checks++; if ({s1, s0} !== {32'd2, 32'd0}) begin n_fail++; $display("FAIL stall_route: got m0=%0d m1=%0d expected m0=0 m1=2", s0, s1); end
        n_checks++; if (prot_err !== 1'b0) begin n_fail++; $display("FAIL stall_prot_err: got %b expected 0", prot_err); end
    endtask

    task automatic test_rready_stall;
        logic [31:0] got[$];
        int b;
        logic hs;
        req(1, 4'h3, 32'h0000_3000, 4'd2);
        tick();
        drop_req();
        addr_hs();
        b = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            m1_if.RREADY = !(cyc >= 1 && cyc <= 3);
            s_if.RVALID  = 1'b1;
            s_if.RDATA   = 32'hBEEF_0000 + 32'(b);
            s_if.RLAST   = (b == 2);
            settle();
            if (cyc >= 1 && cyc <= 3) begin
                n_checks++; if ({s_if.RREADY, m1_if.RVALID} !== 2'b01) begin n_fail++; $display("FAIL rstall%0d_rready_s: got rrdy/m1v=%b expected 01", cyc, {s_if.RREADY, m1_if.RVALID}); end
            end
            hs = s_if.RVALID && s_if.RREADY && m1_if.RVALID;
            if (hs) begin
                got.push_back(m1_if.RDATA);
                b++;
            end
            tick();
        end
        s_if.RVALID = 1'b0;
        s_if.RLAST  = 1'b0;
        m1_if.RREADY = 1'b1;
        n_checks++; if (got.size() !== 3) begin n_fail++; $display("FAIL rstall_beat_count: got %0d expected 3", got.size()); end
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (got[i] !== 32'hBEEF_0000 + 32'(i)) begin n_fail++; $display("FAIL rstall_beat%0d_data: got %h expected %h", i, got[i], 32'hBEEF_0000 + 32'(i)); end
        end
        n_checks++; if (prot_err !== 1'b0) begin n_fail++; $display("FAIL rstall_prot_err: got %b expected 0", prot_err); end
    endtask

    task automatic test_prot_err;
        int s0, s1;
        // Early RLAST: 2nd beat of a 4-beat burst.
        req(0, 4'h2, 32'h0000_4000, 4'd3);
        tick();
        drop_req();
        addr_hs();
        run_beats(2, 1, s0, s1);
        n_checks++; if (prot_err !== 1'b1) begin n_fail++; $display("FAIL perr_early_last: got %b expected 1", prot_err); end
        req(0, 4'h2, 32'h0000_4100, 4'd0);
        settle();
        n_checks++; if (m0_if.ARREADY !== 1'b1) begin n_fail++; $display("FAIL perr_back_to_idle: got %b expected 1", m0_if.ARREADY); end
        tick();
        drop_req();
        addr_hs();
        run_beats(1, 0, s0, s1);
        n_checks++; if (prot_err !== 1'b1) begin n_fail++; $display("FAIL perr_sticky: got %b expected 1", prot_err); end
        // Missing RLAST: beat count reaches ARLEN without it.
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        req(0, 4'h4, 32'h0000_5000, 4'd1);
        tick();
        drop_req();
        addr_hs();
        run_beats(1, 9, s0, s1);
        n_checks++; if (prot_err !== 1'b0) begin n_fail++; $display("FAIL perr_first_beat_ok: got %b expected 0", prot_err); end
        run_beats(1, 9, s0, s1);
        n_checks++; if (prot_err !== 1'b1) begin n_fail++; $display("FAIL perr_missing_last: got %b expected 1", prot_err); end
        run_beats(1, 0, s0, s1);
    endtask

    task automatic test_reset_mid;
        int s0, s1;
        req(0, 4'h1, 32'h0000_1000, 4'd3);
        tick();
        drop_req();
        addr_hs();
        run_beats(1, 9, s0, s1);
        s_if.RVALID = 1'b1;
        s_if.RLAST  = 1'b0;
        rstn = 1'b0;
        tick();
        n_checks++; if ({s_if.ARVALID, s_if.RREADY, m0_if.RVALID, m1_if.RVALID, prot_err} !== 5'b00000) begin n_fail++; $display("FAIL rmid_outputs: got arv/rrdy/m0v/m1v/perr=%b expected 00000", {s_if.ARVALID, s_if.RREADY, m0_if.RVALID, m1_if.RVALID, prot_err}); end
        n_checks++; if ({s_if.ARID, s_if.ARADDR, s_if.ARLEN} !== 44'h0) begin n_fail++; $display("FAIL rmid_ar_fields: got %h expected 0", {s_if.ARID, s_if.ARADDR, s_if.ARLEN}); end
        rstn = 1'b1;
        s_if.RVALID = 1'b0;
        req(1, 4'h7, 32'h0000_2000, 4'd1);
        settle();
        n_checks++; if ({m1_if.ARREADY, m0_if.ARREADY} !== 2'b10) begin n_fail++; $display("FAIL rmid_m1_arready: got %b expected 10", {m1_if.ARREADY, m0_if.ARREADY}); end
        tick();
        drop_req();
        settle();
        n_checks++; if (s_if.ARID !== 8'h27) begin n_fail++; $display("FAIL rmid_arid_s: got %h expected 27", s_if.ARID); end
        addr_hs();
        run_beats(2, 1, s0, s1);
        n_checks++; if ({s1, s0} !== {32'd2, 32'd0}) begin n_fail++; $display("FAIL rmid_route: got m0=%0d m1=%0d expected m0=0 m1=2", s0, s1); end
        n_checks++; if (prot_err !== 1'b0) begin n_fail++; $display("FAIL rmid_prot_err: got %b expected 0", prot_err); end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single();
        test_round_robin();
        test_addr_stall();
        test_rready_stall();
        test_prot_err();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1);
    end

endmodule
